// File: rtl/reg_seq_pkg.sv
// Shared types for the register transfer sequencer.
// Register codes, opcode fields, FSM states, helpers.
package reg_seq_pkg;

  typedef enum logic [2:0] {
    A  = 3'd0,
    B  = 3'd1,
    C  = 3'd2,
    D  = 3'd3,
    M1 = 3'd4,
    M2 = 3'd5,
    X  = 3'd6,
    Y  = 3'd7
  } reg_code_e;

  localparam logic [1:0] OP_MOV8  = 2'b00;
  localparam logic [1:0] OP_SETAB = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    LOAD = 2'd2,
    POST = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    K_MOV = 2'd0,
    K_SET = 2'd1,
    K_ILL = 2'd2
  } kind_e;

  function automatic logic [7:0] sext5to8(
    input logic [4:0] v
  );
    return {{3{v[4]}}, v};
  endfunction

endpackage

// File: rtl/reg_seq_decode.sv
// Combinational instruction decoder.
// Splits a byte into kind, one-hot src/dst, clr, imm.
module reg_seq_decode
  import reg_seq_pkg::*;
(
  input  logic [7:0] instr,
  output kind_e      kind,
  output logic [7:0] src,
  output logic [7:0] dst,
  output logic       clr,
  output logic [7:0] imm
);

  // Decode opcode field and operands.
  always_comb begin
    kind = K_ILL;
    src  = '0;
    dst  = '0;
    clr  = 1'b0;
    imm  = '0;
    unique case (1'b1)
      instr[7]: kind = K_ILL;
      (instr[7:6] == OP_MOV8): begin
        kind = K_MOV;
        src  = 8'b1 << instr[2:0];
        dst  = 8'b1 << instr[5:3];
        clr  = (instr[5:3] == instr[2:0]);
      end
      default: begin
        kind = K_SET;
        dst  = instr[5] ? 8'h02 : 8'h01;
        imm  = sext5to8(instr[4:0]);
      end
    endcase
  end

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Break-before-make strobe sequencer.
// Drives select/load strobes for the register unit.
module reg_transfer_sequencer
  import reg_seq_pkg::*;
#(
  parameter int PRE_CYC  = 1,
  parameter int LD_CYC   = 2,
  parameter int POST_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [7:0] sel,
  output logic [7:0] ld,
  output logic       imm_drive,
  output logic [7:0] imm_data,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  localparam logic [2:0] PRE_N  = 3'(PRE_CYC - 1);
  localparam logic [2:0] LD_N   = 3'(LD_CYC - 1);
  localparam logic [2:0] POST_N = 3'(POST_CYC - 1);

  seq_state_e state, nstate;
  logic [2:0] cnt, ncnt;
  logic [7:0] ir;
  logic       accept;
  logic [7:0] dec_in;

  kind_e      kind;
  logic [7:0] src, dst, imm;
  logic       clr;

  logic       active;
  logic [7:0] nsel, nld, nimm;
  logic       ndrv, ndone, nill;

  assign accept = (state == IDLE) && instr_valid;
  assign dec_in = accept ? instr : ir;

  reg_seq_decode u_dec (
    .instr (dec_in),
    .kind  (kind),
    .src   (src),
    .dst   (dst),
    .clr   (clr),
    .imm   (imm)
  );

  // State, counter and instruction register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ir    <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      if (accept) ir <= instr;
    end
  end

  // Next-state and counter reload.
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    unique case (state)
      IDLE: begin
        if (instr_valid) begin
          nstate = PRE;
          ncnt   = PRE_N;
        end
      end
      PRE: begin
        if (kind == K_ILL) begin
          nstate = IDLE;
          ncnt   = '0;
        end else if (cnt == '0) begin
          nstate = LOAD;
          ncnt   = LD_N;
        end else begin
          ncnt = cnt - 3'd1;
        end
      end
      LOAD: begin
        if (cnt == '0) begin
          nstate = POST;
          ncnt   = POST_N;
        end else begin
          ncnt = cnt - 3'd1;
        end
      end
      POST: begin
        if (cnt == '0) begin
          nstate = IDLE;
          ncnt   = '0;
        end else begin
          ncnt = cnt - 3'd1;
        end
      end
      default: begin
        nstate = IDLE;
        ncnt   = '0;
      end
    endcase
  end

  // Output values for the coming cycle.
  always_comb begin
    active = (nstate != IDLE) && (kind != K_ILL);
    nsel   = '0;
    nld    = '0;
    nimm   = '0;
    ndrv   = 1'b0;
    if (active && kind == K_MOV && !clr)
      nsel = src;
    if (active && kind == K_SET) begin
      ndrv = 1'b1;
      nimm = imm;
    end
    if (nstate == LOAD)
      nld = dst;
    ndone = (nstate == POST) && (ncnt == '0);
    nill  = (nstate == PRE) && (kind == K_ILL);
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel         <= '0;
      ld          <= '0;
      imm_drive   <= 1'b0;
      imm_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      sel         <= nsel;
      ld          <= nld;
      imm_drive   <= ndrv;
      imm_data    <= nimm;
      busy        <= (nstate != IDLE);
      done        <= ndone;
      illegal     <= nill;
      instr_ready <= (nstate == IDLE);
    end
  end

endmodule
